// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path:
// opcodes, ALU op encodings, sequencer states and IR field positions.
package cpu_pkg;

    localparam int OPW  = 5;
    localparam int ALUW = 4;

    localparam int IR_OP_HI = 31;
    localparam int IR_OP_LO = 27;

    localparam logic [OPW-1:0] OP_LD   = 5'd0;
    localparam logic [OPW-1:0] OP_ST   = 5'd1;
    localparam logic [OPW-1:0] OP_ADD  = 5'd2;
    localparam logic [OPW-1:0] OP_SUB  = 5'd3;
    localparam logic [OPW-1:0] OP_AND  = 5'd4;
    localparam logic [OPW-1:0] OP_OR   = 5'd5;
    localparam logic [OPW-1:0] OP_ADDI = 5'd6;
    localparam logic [OPW-1:0] OP_MUL  = 5'd7;
    localparam logic [OPW-1:0] OP_DIV  = 5'd8;
    localparam logic [OPW-1:0] OP_MFHI = 5'd9;
    localparam logic [OPW-1:0] OP_MFLO = 5'd10;
    localparam logic [OPW-1:0] OP_JR   = 5'd11;
    localparam logic [OPW-1:0] OP_NOP  = 5'd12;
    localparam logic [OPW-1:0] OP_HALT = 5'd13;

    localparam logic [ALUW-1:0] ALU_ADD = 4'd0;
    localparam logic [ALUW-1:0] ALU_SUB = 4'd1;
    localparam logic [ALUW-1:0] ALU_AND = 4'd2;
    localparam logic [ALUW-1:0] ALU_OR  = 4'd3;
    localparam logic [ALUW-1:0] ALU_MUL = 4'd4;
    localparam logic [ALUW-1:0] ALU_DIV = 4'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_F2,
        S_E3,
        S_E4,
        S_E5,
        S_E6,
        S_E7,
        S_HALT,
        S_FAULT
    } state_e;

    typedef enum logic [3:0] {
        C_ALU3,
        C_ADDI,
        C_MULDIV,
        C_LD,
        C_ST,
        C_MFHI,
        C_MFLO,
        C_JR,
        C_NOP,
        C_HALT,
        C_ILL
    } iclass_e;

endpackage

// File: rtl/instr_class.sv
// Combinational opcode classifier.
// Ports: opcode_i -> class_o, alu_op_o (function used in E4), illegal_o.
module instr_class
    import cpu_pkg::*;
(
    input  logic [OPW-1:0]  opcode_i,
    output iclass_e         class_o,
    output logic [ALUW-1:0] alu_op_o,
    output logic            illegal_o
);

    always_comb begin
        class_o   = C_ILL;
        alu_op_o  = ALU_ADD;
        illegal_o = 1'b0;
        unique case (opcode_i)
            OP_LD:   class_o = C_LD;
            OP_ST:   class_o = C_ST;
            OP_ADD:  class_o = C_ALU3;
            OP_SUB: begin
                class_o  = C_ALU3;
                alu_op_o = ALU_SUB;
            end
            OP_AND: begin
                class_o  = C_ALU3;
                alu_op_o = ALU_AND;
            end
            OP_OR: begin
                class_o  = C_ALU3;
                alu_op_o = ALU_OR;
            end
            OP_ADDI: class_o = C_ADDI;
            OP_MUL: begin
                class_o  = C_MULDIV;
                alu_op_o = ALU_MUL;
            end
            OP_DIV: begin
                class_o  = C_MULDIV;
                alu_op_o = ALU_DIV;
            end
            OP_MFHI: class_o = C_MFHI;
            OP_MFLO: class_o = C_MFLO;
            OP_JR:   class_o = C_JR;
            OP_NOP:  class_o = C_NOP;
            OP_HALT: class_o = C_HALT;
            default: begin
                class_o   = C_ILL;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control FSM for the 32-bit bus datapath.
// Ports: clock, clear (async, active-low), start, ir, mem_ready in;
//   datapath strobes, register selects, alu_op, halted, fault out.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            start,
    input  logic [31:0]     ir,
    input  logic            mem_ready,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zlowout,
    output logic            ZHighout,
    output logic            HIin,
    output logic            LOin,
    output logic            HIout,
    output logic            LOout,
    output logic            Cout,
    output logic            Read,
    output logic            Write,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic [ALUW-1:0] alu_op,
    output logic            halted,
    output logic            fault
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            halted_q, halted_d;
    logic            fault_q, fault_d;

    iclass_e         cls;
    logic [ALUW-1:0] cls_alu;
    logic            cls_ill;

    instr_class u_cls (
        .opcode_i  (ir[IR_OP_HI:IR_OP_LO]),
        .class_o   (cls),
        .alu_op_o  (cls_alu),
        .illegal_o (cls_ill)
    );

    // Memory-wait handling shared by F1, ld E6 and st E7:
    // advance on mem_ready, else count; timeout diverts to FAULT.
    function automatic void mem_wait(
        input  state_e        nxt,
        input  logic          rdy,
        input  logic [CW-1:0] cnt,
        output state_e        st,
        output logic [CW-1:0] cn
    );
        st = S_FAULT;
        cn = '0;
        if (rdy) begin
            st = nxt;
        end else if (cnt != TMO) begin
            st = S_F1;
            cn = cnt + CW'(1);
        end
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_F0;
            S_F0:   state_d = S_F1;
            S_F1: begin
                mem_wait(S_F2, mem_ready, cnt_q, state_d, cnt_d);
            end
            S_F2:   state_d = S_E3;
            S_E3: begin
                unique case (cls)
                    C_HALT:  state_d = S_HALT;
                    C_ILL:   state_d = S_FAULT;
                    C_MFHI,
                    C_MFLO,
                    C_JR,
                    C_NOP:   state_d = S_F0;
                    default: state_d = S_E4;
                endcase
            end
            S_E4:   state_d = S_E5;
            S_E5: begin
                if (cls == C_ALU3 || cls == C_ADDI)
                    state_d = S_F0;
                else
                    state_d = S_E6;
            end
            S_E6: begin
                if (cls == C_LD) begin
                    mem_wait(S_E7, mem_ready, cnt_q, state_d, cnt_d);
                    if (state_d == S_F1) state_d = S_E6;
                end else if (cls == C_ST) begin
                    state_d = S_E7;
                end else begin
                    state_d = S_F0;
                end
            end
            S_E7: begin
                if (cls == C_ST) begin
                    mem_wait(S_F0, mem_ready, cnt_q, state_d, cnt_d);
                    if (state_d == S_F1) state_d = S_E7;
                end else begin
                    state_d = S_F0;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        halted_d = halted_q | (state_d == S_HALT);
        fault_d  = fault_q | (state_d == S_FAULT);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign halted = halted_q;
    assign fault  = fault_q;

    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
        IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
        Zlowout = 1'b0; ZHighout = 1'b0;
        HIin = 1'b0; LOin = 1'b0;
        HIout = 1'b0; LOout = 1'b0; Cout = 1'b0;
        Read = 1'b0; Write = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        alu_op = ALU_ADD;
        unique case (state_q)
            S_F0: begin
                PCout = 1'b1; MARin = 1'b1;
                IncPC = 1'b1; Zin = 1'b1;
            end
            S_F1: begin
                Zlowout = 1'b1; PCin = 1'b1;
                Read = 1'b1; MDRin = 1'b1;
            end
            S_F2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_E3: begin
                unique case (cls)
                    C_ALU3, C_ADDI: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    C_MULDIV: begin
                        Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    C_LD, C_ST: begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end
                    C_MFHI: begin
                        HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    C_MFLO: begin
                        LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    C_JR: begin
                        Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_E4: begin
                Zin    = 1'b1;
                alu_op = cls_alu;
                unique case (cls)
                    C_ALU3: begin
                        Grc = 1'b1; Rout = 1'b1;
                    end
                    C_MULDIV: begin
                        Grb = 1'b1; Rout = 1'b1;
                    end
                    default: Cout = 1'b1;
                endcase
            end
            S_E5: begin
                Zlowout = 1'b1;
                unique case (cls)
                    C_ALU3, C_ADDI: begin
                        Gra = 1'b1; Rin = 1'b1;
                    end
                    C_MULDIV: LOin = 1'b1;
                    default:  MARin = 1'b1;
                endcase
            end
            S_E6: begin
                unique case (cls)
                    C_MULDIV: begin
                        ZHighout = 1'b1; HIin = 1'b1;
                    end
                    C_LD: begin
                        Read = 1'b1; MDRin = 1'b1;
                    end
                    C_ST: begin
                        Gra = 1'b1; Rout = 1'b1;
                        MDRin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_E7: begin
                unique case (cls)
                    C_LD: begin
                        MDRout = 1'b1; Gra = 1'b1;
                        Rin = 1'b1;
                    end
                    C_ST:    Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    logic unused;
    assign unused = cls_ill ^ ^ir[IR_OP_LO-1:0];

endmodule
